qeciphy_drp_arbiter: RTL

Round-robin arbiter and sequencer for the GT transceiver DRP port, in the fclk domain. It shares the single DRP interface between NUM_REQ internal requesters, such as link-tuning logic and a register-bus bridge. It issues one DRP transaction at a time and guards each one with a ready timeout. DRP access is held off until the reset sequencing reports the GT out of reset.

---
 rtl/qeciphy_drp_arbiter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/qeciphy_drp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : qeciphy_drp_arbiter
//  Brief    : Round-robin arbiter and sequencer for the GT transceiver DRP
//             port. Serialises NUM_REQ requesters onto one DRP interface,
//             one transaction at a time, each one bounded by a ready timeout.
//             New grants are held off while the GT is not out of reset.
//  Revision : 1.0 - initial release
// ============================================================================
module qeciphy_drp_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                      fclk,
    input  logic                      fclk_rst_n,
    input  logic                      i_drp_allow,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ-1:0]        i_we,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
    output logic [NUM_REQ-1:0]        o_ack,
    output logic [NUM_REQ-1:0]        o_err,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_busy,
    output logic                      o_drp_en,
    output logic                      o_drp_we,
    output logic [ADDR_W-1:0]         o_drp_addr,
    output logic [DATA_W-1:0]         o_drp_di,
    input  logic [DATA_W-1:0]         i_drp_do,
    input  logic                      i_drp_rdy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_TW = $clog2(TIMEOUT + 1);
    localparam int c_GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [c_TW-1:0] c_TIMEOUT  = c_TW'(TIMEOUT);
    localparam logic [c_GW-1:0] c_LAST_RST = c_GW'(NUM_REQ - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;
    localparam logic [1:0] c_S_RESP  = 2'd3;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [c_GW-1:0]   r_gnt;
    logic [c_GW-1:0]   r_last_gnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_di;
    logic [c_TW-1:0]   r_cnt;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [1:0]         w_state_nxt;
    logic [c_GW-1:0]    w_win;
    logic [c_GW-1:0]    w_idx;
    int                 w_pos;
    logic               w_found;
    logic               w_grant;
    logic               w_cnt_done;
    logic [NUM_REQ-1:0] w_gnt_onehot;

    logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];

    // Split the packed per-requester buses into indexable arrays
    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign w_addr_arr[g]  = i_addr[g*ADDR_W +: ADDR_W];
            assign w_wdata_arr[g] = i_wdata[g*DATA_W +: DATA_W];
        end
    endgenerate

    // Round-robin search: first set request above the last grant, with wrap
    always_comb begin
        w_win   = '0;
        w_idx   = '0;
        w_pos   = 0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pos = (int'(r_last_gnt) + 1 + i) % NUM_REQ;
            w_idx = c_GW'(w_pos);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // A grant is only taken while the GT reports it is out of reset
    assign w_grant      = i_drp_allow & w_found;
    assign w_cnt_done   = (r_cnt == c_TIMEOUT);
    assign w_gnt_onehot = NUM_REQ'(1) << r_gnt;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge fclk or negedge fclk_rst_n) begin
        if (!fclk_rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a ready in the final timeout cycle still counts
    always_comb begin
        w_state_nxt = c_S_IDLE;
        case (r_state)
            c_S_IDLE: begin
                w_state_nxt = w_grant ? c_S_ISSUE : c_S_IDLE;
            end
            c_S_ISSUE: begin
                w_state_nxt = c_S_WAIT;
            end
            c_S_WAIT: begin
                if (i_drp_rdy || w_cnt_done) begin
                    w_state_nxt = c_S_RESP;
                end else begin
                    w_state_nxt = c_S_WAIT;
                end
            end
            c_S_RESP: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Output decode, driven only from registered state
    always_comb begin
        o_ack    = '0;
        o_err    = '0;
        o_rdata  = '0;
        o_busy   = 1'b1;
        o_drp_en = 1'b0;
        o_drp_we = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                o_busy = 1'b0;
            end
            c_S_ISSUE: begin
                o_drp_en = 1'b1;
                o_drp_we = r_we;
            end
            c_S_WAIT: begin
                o_busy = 1'b1;
            end
            c_S_RESP: begin
                o_ack   = w_gnt_onehot;
                o_err   = r_err ? w_gnt_onehot : '0;
                // Writes return no data
                o_rdata = r_we ? '0 : r_rdata;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    // DRP address/data are held from the grant until the next grant
    assign o_drp_addr = r_addr;
    assign o_drp_di   = r_di;

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // Grant capture and round-robin pointer update
    always_ff @(posedge fclk or negedge fclk_rst_n) begin
        if (!fclk_rst_n) begin
            r_gnt      <= '0;
            r_last_gnt <= c_LAST_RST;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_di       <= '0;
        end else begin
            if ((r_state == c_S_IDLE) && w_grant) begin
                r_gnt  <= w_win;
                r_we   <= i_we[w_win];
                r_addr <= w_addr_arr[w_win];
                r_di   <= w_wdata_arr[w_win];
            end
            if (r_state == c_S_RESP) begin
                r_last_gnt <= r_gnt;
            end
        end
    end

    // Ready timeout counter: cleared on issue, advances while waiting
    always_ff @(posedge fclk or negedge fclk_rst_n) begin
        if (!fclk_rst_n) begin
            r_cnt <= '0;
        end else if (r_state == c_S_ISSUE) begin
            r_cnt <= '0;
        end else if ((r_state == c_S_WAIT) && !i_drp_rdy && !w_cnt_done) begin
            r_cnt <= r_cnt + c_TW'(1);
        end
    end

    // Response capture; ready outside WAIT (e.g. stale strobes) is ignored
    always_ff @(posedge fclk or negedge fclk_rst_n) begin
        if (!fclk_rst_n) begin
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else if (r_state == c_S_WAIT) begin
            if (i_drp_rdy) begin
                r_err   <= 1'b0;
                r_rdata <= i_drp_do;
            end else if (w_cnt_done) begin
                r_err   <= 1'b1;
                r_rdata <= '0;
            end
        end
    end

endmodule
`default_nettype wire
